// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state codes, cause bit
// positions and the state-to-output decode.
package reset_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t QUAL    = 3'd1;
    localparam state_t FULL    = 3'd2;
    localparam state_t HOLD    = 3'd3;
    localparam state_t SPECIAL = 3'd4;

    localparam int CAUSE_POR   = 0;
    localparam int CAUSE_PIN   = 1;
    localparam int CAUSE_WDT   = 2;
    localparam int CAUSE_SOFT0 = 3;

    // Returns {reset, clrpc}; a QUAL entered from SPECIAL keeps the PC clear pending.
    function automatic logic [1:0] out_decode(input state_t st, input logic spec_pend);
        logic [1:0] v;
        case (st)
            FULL, HOLD: v = 2'b11;
            SPECIAL:    v = 2'b01;
            QUAL:       v = {1'b0, spec_pend};
            default:    v = 2'b00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/reset_seq_sync_stages.sv
// Parametrised N-flop synchroniser with asynchronous active-high clear.
module sync_stages #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift chain; bit 0 samples the asynchronous input.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_sync <= {STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Sequenced internal reset: pin qualification, Z80 special reset, stretch and
// sticky cause. Optional watchdog source enabled by defining RESET_WDT_EN.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int QUAL_CYCLES = 3,
    parameter int STRETCH     = 2,
    parameter int NUM_SOFT    = 1,
    parameter int WDT_WIDTH   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_fpga_reset,
    input  logic                  i_reset_in,
    input  logic [NUM_SOFT-1:0]   i_soft_req,
    input  logic                  i_m1,
    input  logic                  i_t2,
    input  logic                  i_wdt_kick,
    input  logic                  i_cause_clr,
    output logic                  o_reset,
    output logic                  o_nreset,
    output logic                  o_clrpc,
    output logic [NUM_SOFT+2:0]   o_cause
);

    localparam int CMAX = (QUAL_CYCLES > STRETCH) ? QUAL_CYCLES : STRETCH;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int CZ   = NUM_SOFT + 3;
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] QUAL_LAST    = CW'(QUAL_CYCLES - 1);
    localparam logic [CW-1:0] STRETCH_LAST = (STRETCH > 1) ? CW'(STRETCH - 1) : {CW{1'b0}};
    localparam logic [CZ-1:0] CAUSE_RST    = CZ'(1) << CAUSE_POR;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic            r_m1_cap, w_m1_cap_nxt;
    logic            r_spec_pend, w_spec_pend_nxt;
    logic            r_pin_d;
    logic            r_reset, r_nreset, r_clrpc;
    logic [CZ-1:0]   r_cause, w_set;
    logic            w_pin_s, w_pin_rise, w_pin_full;
    logic            w_wdt_exp, w_hard_req, w_any_req;
    logic [1:0]      w_out_nxt;

    sync_stages #(.STAGES(SYNC_STAGES)) u_pin_sync (
        .i_clk (i_clk),
        .i_clr (i_fpga_reset),
        .i_d   (i_reset_in),
        .o_q   (w_pin_s)
    );

`ifdef RESET_WDT_EN
    logic [WDT_WIDTH-1:0] r_wdt;

    assign w_wdt_exp = &r_wdt;

    // Watchdog runs only while the core is out of reset; a kick beats the increment.
    always_ff @(posedge i_clk or posedge i_fpga_reset) begin
        if (i_fpga_reset) begin
            r_wdt <= {WDT_WIDTH{1'b0}};
        end else if (i_wdt_kick || w_wdt_exp || r_reset) begin
            r_wdt <= {WDT_WIDTH{1'b0}};
        end else if (r_state == IDLE || r_state == SPECIAL) begin
            r_wdt <= r_wdt + {{(WDT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_wdt <= r_wdt;
        end
    end
`else
    logic w_unused_kick;
    assign w_unused_kick = i_wdt_kick;
    assign w_wdt_exp     = 1'b0;
`endif

    assign w_pin_rise = w_pin_s & ~r_pin_d;
    assign w_hard_req = (|i_soft_req) | w_wdt_exp;
    assign w_any_req  = w_hard_req | w_pin_s;
    assign w_cnt_inc  = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;

    // Next-state logic; soft/watchdog requests always pre-empt the pin path.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_m1_cap_nxt    = r_m1_cap;
        w_spec_pend_nxt = r_spec_pend;
        w_pin_full      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hard_req) begin
                    w_state_nxt = FULL;
                end else if (w_pin_rise) begin
                    w_state_nxt     = QUAL;
                    w_cnt_nxt       = CNT_ONE;
                    w_m1_cap_nxt    = i_m1;
                    w_spec_pend_nxt = 1'b0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            QUAL: begin
                if (w_hard_req) begin
                    w_state_nxt = FULL;
                end else if (w_pin_s) begin
                    if (r_cnt >= QUAL_LAST) begin
                        w_state_nxt = FULL;
                        w_pin_full  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (r_m1_cap) begin
                    w_state_nxt = SPECIAL;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FULL: begin
                if (w_any_req) begin
                    w_state_nxt = FULL;
                end else if (STRETCH == 0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = {CW{1'b0}};
                end
            end
            HOLD: begin
                if (w_any_req) begin
                    w_state_nxt = FULL;
                    w_pin_full  = w_pin_s;
                end else if (r_cnt >= STRETCH_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            SPECIAL: begin
                if (w_hard_req) begin
                    w_state_nxt = FULL;
                end else if (w_pin_rise) begin
                    // A glitch during this QUAL must fall back here, so force m1_cap.
                    w_state_nxt     = QUAL;
                    w_cnt_nxt       = CNT_ONE;
                    w_m1_cap_nxt    = 1'b1;
                    w_spec_pend_nxt = 1'b1;
                end else if (i_m1 && i_t2) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = SPECIAL;
                end
            end
            default: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Cause bits raised by whichever sources cause entry into FULL.
    always_comb begin
        w_set = {CZ{1'b0}};
        if (w_state_nxt == FULL && r_state != FULL) begin
            w_set[CAUSE_PIN]                = w_pin_full;
            w_set[CAUSE_WDT]                = w_wdt_exp;
            w_set[CAUSE_SOFT0 +: NUM_SOFT] = i_soft_req;
        end else begin
            w_set = {CZ{1'b0}};
        end
    end

    assign w_out_nxt = out_decode(w_state_nxt, w_spec_pend_nxt);

    // FSM state and output registers; outputs track the state they enter with.
    always_ff @(posedge i_clk or posedge i_fpga_reset) begin
        if (i_fpga_reset) begin
            r_state     <= HOLD;
            r_cnt       <= {CW{1'b0}};
            r_m1_cap    <= 1'b0;
            r_spec_pend <= 1'b0;
            r_pin_d     <= 1'b0;
            r_reset     <= 1'b1;
            r_nreset    <= 1'b0;
            r_clrpc     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_m1_cap    <= w_m1_cap_nxt;
            r_spec_pend <= w_spec_pend_nxt;
            r_pin_d     <= w_pin_s;
            r_reset     <= w_out_nxt[1];
            r_nreset    <= ~w_out_nxt[1];
            r_clrpc     <= w_out_nxt[0];
        end
    end

    // Sticky cause register; a bit being set survives a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_fpga_reset) begin
        if (i_fpga_reset) begin
            r_cause <= CAUSE_RST;
        end else if (i_cause_clr) begin
            r_cause <= w_set;
        end else begin
            r_cause <= r_cause | w_set;
        end
    end

    assign o_reset  = r_reset;
    assign o_nreset = r_nreset;
    assign o_clrpc  = r_clrpc;
    assign o_cause  = r_cause;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: stimulus queues expected output vectors
// {reset, nreset, clrpc, cause} tagged with a cycle; a monitor compares them.
module tb_reset_seq;

    logic       clk        = 1'b0;
    logic       fpga_reset = 1'b1;
    logic       reset_in   = 1'b0;
    logic [0:0] soft_req   = 1'b0;
    logic       m1         = 1'b0;
    logic       t2         = 1'b0;
    logic       wdt_kick   = 1'b1;
    logic       cause_clr  = 1'b0;
    logic       o_reset, o_nreset, o_clrpc;
    logic [3:0] o_cause;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        string      nm;
        logic [6:0] v;
    } exp_t;

    exp_t sb_q[$];

    reset_seq #(.WDT_WIDTH(4)) dut (
        .i_clk        (clk),
        .i_fpga_reset (fpga_reset),
        .i_reset_in   (reset_in),
        .i_soft_req   (soft_req),
        .i_m1         (m1),
        .i_t2         (t2),
        .i_wdt_kick   (wdt_kick),
        .i_cause_clr  (cause_clr),
        .o_reset      (o_reset),
        .o_nreset     (o_nreset),
        .o_clrpc      (o_clrpc),
        .o_cause      (o_cause)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compare every expectation due at this cycle on the falling edge.
    initial begin
        logic [6:0] obs;
        forever begin
            @(negedge clk);
            obs = {o_reset, o_nreset, o_clrpc, o_cause};
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc <= cyc) begin
                    checks++;
                    if (sb_q[i].cyc < cyc || obs !== sb_q[i].v) begin
                        errors++;
                        $display("FAIL %s cyc=%0d got=%b expected=%b (due cyc %0d)",
                                 sb_q[i].nm, cyc, obs, sb_q[i].v, sb_q[i].cyc);
                    end
                    sb_q.delete(i);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_at(input int d, input string nm, input logic [6:0] v);
        exp_t e;
        e.cyc = cyc + d;
        e.nm  = nm;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    initial begin
        // Power-on: reset held, then STRETCH=2 cycles after release.
        tick(1);
        exp_at(0, "por_assert",  {3'b101, 4'b0001});
        fpga_reset = 1'b0;
        exp_at(1, "por_stretch", {3'b101, 4'b0001});
        exp_at(2, "por_release", {3'b010, 4'b0001});
        tick(2);
        checks++;
        if ({o_reset, o_nreset, o_clrpc, o_cause} !== 7'b0100001) begin
            errors++;
            $display("FAIL direct_por_release got=%b", {o_reset, o_nreset, o_clrpc, o_cause});
        end
        cause_clr = 1'b1;
        exp_at(1, "cause_clr", {3'b010, 4'b0000});
        tick(1);
        cause_clr = 1'b0;

        // Long pin pulse, M1=0: full reset at sync+qual, stretched after pin_s falls.
        reset_in = 1'b1;
        m1       = 1'b0;
        exp_at(4,  "pin_qual_low", {3'b010, 4'b0000});
        exp_at(5,  "pin_full",     {3'b101, 4'b0010});
        exp_at(9,  "pin_stretch",  {3'b101, 4'b0010});
        exp_at(10, "pin_release",  {3'b010, 4'b0010});
        tick(5);
        checks++;
        if ({o_reset, o_nreset, o_clrpc, o_cause} !== 7'b1010010) begin
            errors++;
            $display("FAIL direct_pin_full got=%b", {o_reset, o_nreset, o_clrpc, o_cause});
        end
        reset_in = 1'b0;
        tick(6);
        cause_clr = 1'b1;
        exp_at(1, "cause_clr2", {3'b010, 4'b0000});
        tick(1);
        cause_clr = 1'b0;

        // Short pin pulse starting in M1: special reset, clrpc until M1&T2.
        reset_in = 1'b1;
        m1       = 1'b1;
        exp_at(3, "spec_qual",    {3'b010, 4'b0000});
        exp_at(4, "spec_clrpc",   {3'b011, 4'b0000});
        exp_at(7, "spec_hold",    {3'b011, 4'b0000});
        exp_at(8, "spec_m1_only", {3'b011, 4'b0000});
        exp_at(9, "spec_done",    {3'b010, 4'b0000});
        tick(1);
        reset_in = 1'b0;
        tick(2);
        m1 = 1'b0;
        tick(4);
        m1 = 1'b1;
        tick(1);
        t2 = 1'b1;
        tick(1);
        m1 = 1'b0;
        t2 = 1'b0;

        // Short pin pulse with M1=0: rejected glitch, nothing changes.
        reset_in = 1'b1;
        exp_at(3, "glitch_qual",   {3'b010, 4'b0000});
        exp_at(4, "glitch_reject", {3'b010, 4'b0000});
        exp_at(6, "glitch_idle",   {3'b010, 4'b0000});
        tick(1);
        reset_in = 1'b0;
        tick(6);

        // Soft request while in SPECIAL, with a simultaneous cause clear.
        reset_in = 1'b1;
        m1       = 1'b1;
        tick(1);
        reset_in = 1'b0;
        tick(2);
        m1 = 1'b0;
        tick(1);
        exp_at(0, "soft_spec_pre", {3'b011, 4'b0000});
        soft_req  = 1'b1;
        cause_clr = 1'b1;
        exp_at(1, "soft_full",    {3'b101, 4'b1000});
        exp_at(3, "soft_stretch", {3'b101, 4'b1000});
        exp_at(4, "soft_release", {3'b010, 4'b1000});
        tick(1);
        checks++;
        if ({o_reset, o_nreset, o_clrpc, o_cause} !== 7'b1011000) begin
            errors++;
            $display("FAIL direct_soft_full got=%b", {o_reset, o_nreset, o_clrpc, o_cause});
        end
        soft_req  = 1'b0;
        cause_clr = 1'b0;
        tick(4);

        // fpga_reset asserted mid-QUAL aborts immediately.
        reset_in = 1'b1;
        tick(3);
        fpga_reset = 1'b1;
        reset_in   = 1'b0;
        exp_at(0, "async_abort", {3'b101, 4'b0001});
        exp_at(1, "async_held",  {3'b101, 4'b0001});
        tick(1);
        fpga_reset = 1'b0;
        exp_at(1, "async_stretch", {3'b101, 4'b0001});
        exp_at(2, "async_release", {3'b010, 4'b0001});
        tick(3);

`ifdef RESET_WDT_EN
        // Unkicked 4-bit watchdog fires after 15 idle clocks.
        wdt_kick = 1'b0;
        exp_at(15, "wdt_quiet",   {3'b010, 4'b0001});
        exp_at(16, "wdt_fire",    {3'b101, 4'b0101});
        exp_at(19, "wdt_release", {3'b010, 4'b0101});
        tick(20);
        for (int k = 0; k < 5; k++) begin
            wdt_kick = 1'b1;
            tick(1);
            wdt_kick = 1'b0;
            exp_at(9, "wdt_kicked", {3'b010, 4'b0101});
            tick(9);
        end
        wdt_kick = 1'b1;
`endif

        tick(2);
        while (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL unchecked_%s due=%0d now=%0d", sb_q[0].nm, sb_q[0].cyc, cyc);
            sb_q.delete(0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised successor to the CPU reset block.
- Merges the asynchronous reset pin, NUM_SOFT synchronous soft-reset requests and an optional watchdog into one sequenced internal reset.
- Qualifies pin pulses by length. Implements Z80 "special reset" (short pulse starting in M1 clears PC only, CLRPC held until next M1/T2). Stretches internal reset by a programmable count and records a sticky reset cause.
- Sits between the pin pad / system logic and the sequencer / PC logic.

Parameters:
- SYNC_STAGES, 2, flops in the reset_in synchroniser (min 2).
- QUAL_CYCLES, 3, synced pin cycles needed for a full reset.
- STRETCH, 2, extra cycles reset stays high after all requests drop (0 allowed).
- NUM_SOFT, 1, number of soft-reset request inputs (min 1).
- WDT_WIDTH, 16, watchdog counter width (used only with RESET_WDT_EN).

Ports:
- clk  in  1  system clock.
- fpga_reset  in  1  asynchronous, active-high power-on/FPGA reset.
- reset_in  in  1  reset pin, asynchronous, active-high.
- soft_req  in  NUM_SOFT  synchronous soft-reset requests, level.
- M1  in  1  sequencer M1 cycle.
- T2  in  1  sequencer T2 state.
- wdt_kick  in  1  watchdog restart pulse.
- cause_clr  in  1  clears the cause register.
- reset  out  1  internal reset, registered.
- nreset  out  1  inverse of reset, registered.
- clrpc  out  1  load 0 to PC, registered.
- cause  out  NUM_SOFT+3  sticky cause: bit0 power-on, bit1 pin, bit2 watchdog, bit3+i soft_req[i].

Behaviour:
- Pin path: reset_in passes through the SYNC_STAGES synchroniser to give pin_s. Synchroniser flops clear on fpga_reset.
- Counter cnt: width $clog2(max(QUAL_CYCLES,STRETCH)+1). Saturates; never wraps.
- States:
  - IDLE: outputs low.
    - pin_s rising → QUAL, cnt=1, m1_cap=M1.
    - Any soft_req or watchdog expiry → FULL.
    - Soft/watchdog take priority over pin_s in the same cycle.
  - QUAL: reset=0, clrpc=0.
    - pin_s high: cnt+1. When cnt reaches QUAL_CYCLES → FULL, and cause[1] is set.
    - pin_s low before that: m1_cap=1 → SPECIAL; m1_cap=0 → IDLE (glitch rejected, no cause bit).
    - soft/watchdog → FULL immediately.
  - FULL: reset=1, clrpc=1.
    - Remains while any request (pin_s, soft_req, watchdog pending) is high.
    - All requests low → HOLD, cnt=0. With STRETCH=0, go straight to IDLE.
  - HOLD: reset=1, clrpc=1; cnt+1 each cycle.
    - cnt==STRETCH-1 → IDLE.
    - Any request reasserted → FULL.
  - SPECIAL: reset=0, clrpc=1.
    - Leaves to IDLE in the cycle after M1&T2 is sampled high. clrpc is low that cycle.
    - pin_s rising → QUAL with clrpc held 1.
    - soft/watchdog → FULL.
- Cause bits: set on FULL entry by their source. Simultaneous sources set all their bits. cause_clr clears every bit except those being set in the same cycle (set wins).
- Registered outputs: reset, nreset, clrpc are state decodes registered. Latency from qualifying edge to output change is 1 clk. Pin latency is SYNC_STAGES + QUAL_CYCLES clks from the pin edge.
- On fpga_reset (asynchronous):
  - State = HOLD, cnt=0.
  - reset=1, nreset=0, clrpc=1.
  - cause = only bit0 set; watchdog counter = 0; m1_cap=0.
  - After release, reset stays high for STRETCH cycles. If pin_s is still high, FULL is entered on the next clock.
- Asserting fpga_reset mid-operation aborts any state immediately.

Optional Feature:
- RESET_WDT_EN defined:
  - WDT_WIDTH-bit counter increments each clk while state==IDLE or SPECIAL.
  - wdt_kick clears it. If a kick and increment occur together, the kick wins.
  - All-ones → expiry request (one-cycle) → FULL and cause[2]. Counter clears on expiry and while reset=1.
- Undefined: no counter logic; wdt_kick ignored; cause[2] constant 0.

Decomposition:
- Package reset_seq_pkg holds:
  - state enum (IDLE, QUAL, FULL, HOLD, SPECIAL);
  - cause bit index constants (CAUSE_POR=0, CAUSE_PIN=1, CAUSE_WDT=2, CAUSE_SOFT0=3).
- One sub-module, sync_stages: a parametrised N-flop synchroniser with async clear. It is reused later for other pin inputs.

Test Plan:
- Power-on with defaults: fpga_reset high for 1 clk, then low with pins idle → reset high for 2 clks after release, then 0. nreset is the inverse. cause=0001.
- Pin high for 5 clks with M1=0 → after sync+3 clks reset=clrpc=1. Stays high until pin_s falls, +2 clks stretch. cause[1]=1.
- Pin high for 2 synced clks with M1=1 at rise → reset never asserts. clrpc=1 from the fall until the cycle after M1=1,T2=1 (8 clks later), then 0.
- Pin high for 2 clks with M1=0 → no output change, cause unchanged.
- soft_req[0] 1-clk pulse in SPECIAL → FULL: reset=1 next clk, cause[3]=1. A cause_clr in the same cycle leaves cause[3]=1.
- RESET_WDT_EN, WDT_WIDTH=4, no kick → FULL after 15 idle clks with cause[2]=1. Kicking every 10 clks → never fires.
